// File: rtl/mac_int8_array.sv
// INT8 dot-product/accumulate PE with ping-pong stationary weight banks and weight/partial-sum cascade.
// Build option: define MAC_INT8_ARRAY_SAT_EN for saturating accumulators (default wraps modulo 2^ACC_W).
module mac_int8_array #(
  parameter int unsigned LANES = 10,
  parameter int unsigned COLS  = 3,
  parameter int unsigned ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic                   bank_sel,
  input  logic                   data_uns,
  input  logic [8*LANES-1:0]     data_in,
  input  logic                   w_load,
  input  logic                   w_bank,
  input  logic                   w_src,
  input  logic [8*LANES-1:0]     w_data,
  input  logic [8*LANES-1:0]     cascade_weight_in,
  output logic [8*LANES-1:0]     cascade_weight_out,
  output logic                   cascade_weight_valid,
  input  logic [ACC_W*COLS-1:0]  cascade_data_in,
  output logic                   out_valid,
  output logic [ACC_W*COLS-1:0]  result,
  output logic [COLS-1:0]        ovf,
  output logic                   w_conflict
);

  typedef logic [COLS-1:0][8*LANES-1:0] bank_t;
  typedef logic [COLS-1:0][ACC_W-1:0]   accv_t;

  bank_t              bank_a_q, bank_b_q, wsel_bank, shift_d;
  logic [8*LANES-1:0] w_src_vec;
  logic [8*LANES-1:0] cwo_q;
  logic               cwv_q;
  logic               conflict_q;

  logic               s1_valid_q, s1_first_q, s1_last_q, s1_bank_q, s1_uns_q;
  logic [8*LANES-1:0] s1_data_q;
  accv_t              s1_casc_q;

  logic               s2_valid_q, s2_first_q, s2_last_q;
  accv_t              s2_casc_q, dot_d, dot_q;

  accv_t              acc_q, acc_d, result_q, base, sum;
  logic [COLS-1:0]    ovf_q, ovf_hit;
  logic               out_valid_q;

  function automatic logic [ACC_W-1:0] lane_prod(input logic [7:0] a, input logic [7:0] w,
                                                 input logic uns);
    logic signed [8:0]  ax;
    logic signed [16:0] p;
    ax = $signed({uns ? 1'b0 : a[7], a});
    p  = ax * $signed(w);
    return {{(ACC_W-17){p[16]}}, p};
  endfunction

  // Weight shift path: the targeted bank moves one column up, displaced column leaves on the cascade.
  always_comb begin
    w_src_vec = w_src ? cascade_weight_in : w_data;
    shift_d   = '0;
    shift_d[0] = w_src_vec;
    for (int unsigned k = 1; k < COLS; k++) begin
      shift_d[k] = w_bank ? bank_b_q[k-1] : bank_a_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bank_a_q   <= '0;
      bank_b_q   <= '0;
      cwo_q      <= '0;
      cwv_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      cwv_q <= w_load;
      if (w_load) begin
        if (w_bank) bank_b_q <= shift_d;
        else        bank_a_q <= shift_d;
        cwo_q <= w_bank ? bank_b_q[COLS-1] : bank_a_q[COLS-1];
        if ((in_valid && bank_sel == w_bank) || (s1_valid_q && s1_bank_q == w_bank)) begin
          conflict_q <= 1'b1;
        end
      end
    end
  end

  // S1: capture the beat
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bank_q  <= 1'b0;
      s1_uns_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_casc_q  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_first_q <= in_first;
        s1_last_q  <= in_last;
        s1_bank_q  <= bank_sel;
        s1_uns_q   <= data_uns;
        s1_data_q  <= data_in;
        s1_casc_q  <= cascade_data_in;
      end
    end
  end

  // S2: per-column dot product against the bank selected by this beat
  always_comb begin
    wsel_bank = s1_bank_q ? bank_b_q : bank_a_q;
    dot_d     = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        dot_d[c] = dot_d[c] + lane_prod(s1_data_q[8*l +: 8], wsel_bank[c][8*l +: 8], s1_uns_q);
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_casc_q  <= '0;
      dot_q      <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
        s2_casc_q  <= s1_casc_q;
        dot_q      <= dot_d;
      end
    end
  end

  // S3: accumulate, seeding from the cascade on first beats
  always_comb begin
    base    = '0;
    sum     = '0;
    acc_d   = acc_q;
    ovf_hit = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      base[c]    = s2_first_q ? s2_casc_q[c] : acc_q[c];
      sum[c]     = base[c] + dot_q[c];
      ovf_hit[c] = (base[c][ACC_W-1] == dot_q[c][ACC_W-1]) &&
                   (sum[c][ACC_W-1] != base[c][ACC_W-1]);
`ifdef MAC_INT8_ARRAY_SAT_EN
      if (ovf_hit[c]) begin
        sum[c] = base[c][ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
`endif
      acc_d[c] = sum[c];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc_q       <= '0;
      result_q    <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s2_valid_q && s2_last_q;
      if (s2_valid_q) begin
        acc_q <= acc_d;
        ovf_q <= ovf_q | ovf_hit;
        if (s2_last_q) result_q <= acc_d;
      end
    end
  end

  assign cascade_weight_out   = cwo_q;
  assign cascade_weight_valid = cwv_q;
  assign out_valid            = out_valid_q;
  assign result               = result_q;
  assign ovf                  = ovf_q;
  assign w_conflict           = conflict_q;

endmodule

// File: tb/tb_mac_int8_array.sv
// Directed bench for mac_int8_array (ACC_W=22 instance): vector table plus multi-cycle sequences.
module tb_mac_int8_array;
  localparam int LANES = 10;
  localparam int COLS  = 3;
  localparam int AW    = 22;
  localparam int VW    = 8*LANES;
  localparam int RW    = AW*COLS;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, bank_sel = 1'b0, data_uns = 1'b0;
  logic [VW-1:0] data_in = '0;
  logic          w_load = 1'b0, w_bank = 1'b0, w_src = 1'b0;
  logic [VW-1:0] w_data = '0, cascade_weight_in = '0;
  logic [VW-1:0] cascade_weight_out;
  logic          cascade_weight_valid;
  logic [RW-1:0] cascade_data_in = '0;
  logic          out_valid;
  logic [RW-1:0] result;
  logic [COLS-1:0] ovf;
  logic          w_conflict;

  mac_int8_array #(.LANES(LANES), .COLS(COLS), .ACC_W(AW)) dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .bank_sel(bank_sel), .data_uns(data_uns), .data_in(data_in), .w_load(w_load),
    .w_bank(w_bank), .w_src(w_src), .w_data(w_data), .cascade_weight_in(cascade_weight_in),
    .cascade_weight_out(cascade_weight_out), .cascade_weight_valid(cascade_weight_valid),
    .cascade_data_in(cascade_data_in), .out_valid(out_valid), .result(result), .ovf(ovf),
    .w_conflict(w_conflict)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [RW-1:0] res_q[$];

  always @(negedge clk) if (clr_n && out_valid) res_q.push_back(result);

  typedef struct packed {
    logic [2:0][7:0]  w;
    logic [7:0]       d;
    logic             uns;
    logic [2:0][31:0] casc;
    logic [7:0]       nb;
    logic [2:0][31:0] exp;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int col_of(input logic [RW-1:0] r, input int c);
    logic signed [AW-1:0] v;
    v = r[AW*c +: AW];
    return int'(v);
  endfunction

  task automatic load_w(input logic bank, input logic [7:0] b);
    w_load = 1'b1; w_bank = bank; w_src = 1'b0; w_data = {LANES{b}};
    tick();
    w_load = 1'b0;
  endtask

  task automatic fill(input logic bank, input logic [7:0] w0, input logic [7:0] w1,
                      input logic [7:0] w2);
    load_w(bank, w2); load_w(bank, w1); load_w(bank, w0);
  endtask

  task automatic set_beat(input logic f, input logic l, input logic bank, input logic uns,
                          input logic [7:0] d, input logic [2:0][31:0] casc);
    in_valid = 1'b1; in_first = f; in_last = l; bank_sel = bank; data_uns = uns;
    data_in = {LANES{d}};
    for (int c = 0; c < COLS; c++) cascade_data_in[AW*c +: AW] = casc[c][AW-1:0];
  endtask

  task automatic run(input int nb, input logic bank, input logic uns, input logic [7:0] d,
                     input logic [2:0][31:0] casc);
    for (int b = 0; b < nb; b++) begin
      set_beat(b == 0, b == nb-1, bank, uns, d, casc);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
  endtask

  task automatic expect_one(input string nm, input int e0, input int e1, input int e2);
    logic [RW-1:0] r;
    chk({nm, "_count"}, res_q.size(), 1);
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      chk({nm, "_c0"}, col_of(r, 0), e0);
      chk({nm, "_c1"}, col_of(r, 1), e1);
      chk({nm, "_c2"}, col_of(r, 2), e2);
    end
    res_q.delete();
  endtask

  initial begin
    logic [2:0][31:0] z;
    int sat_exp;
    z = '0;

    tbl[0] = '{w: {8'h03, 8'h02, 8'h01}, d: 8'h02, uns: 1'b0, casc: {32'd0, 32'd0, 32'd0},
               nb: 8'd1, exp: {32'd60, 32'd40, 32'd20}};
    tbl[1] = '{w: {8'h80, 8'h80, 8'h80}, d: 8'h80, uns: 1'b0, casc: {32'd0, 32'd0, 32'd5},
               nb: 8'd4, exp: {32'd655360, 32'd655360, 32'd655365}};
    tbl[2] = '{w: {8'h01, 8'h01, 8'h01}, d: 8'hFF, uns: 1'b1, casc: {32'd0, 32'd0, 32'd0},
               nb: 8'd1, exp: {32'd2550, 32'd2550, 32'd2550}};
    tbl[3] = '{w: {8'h01, 8'h01, 8'h01}, d: 8'hFF, uns: 1'b0, casc: {32'd0, 32'd0, 32'd0},
               nb: 8'd1, exp: {-32'sd10, -32'sd10, -32'sd10}};
    tbl[4] = '{w: {8'h7F, 8'hFF, 8'h01}, d: 8'h7F, uns: 1'b0, casc: {-32'sd100, 32'sd100, 32'sd0},
               nb: 8'd2, exp: {32'sd322480, -32'sd2440, 32'sd2540}};

    repeat (2) tick();
    chk("rst_result", longint'(|result), 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_conflict", w_conflict, 0);
    chk("rst_cwv", cascade_weight_valid, 0);
    clr_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      fill(1'b0, tbl[i].w[0], tbl[i].w[1], tbl[i].w[2]);
      run(int'(tbl[i].nb), 1'b0, tbl[i].uns, tbl[i].d, tbl[i].casc);
      expect_one($sformatf("vec%0d", i), int'($signed(tbl[i].exp[0])),
                 int'($signed(tbl[i].exp[1])), int'($signed(tbl[i].exp[2])));
    end

    // Non-first beat continues from the held accumulator; cascade ignored.
    run(1, 1'b0, 1'b0, 8'h01, {32'd7, 32'd7, 32'd7});
    set_beat(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, {32'd7, 32'd7, 32'd7});
    res_q.delete();
    in_valid = 1'b0;
    // (the run above was itself a single non-first beat; check it only via re-derivation below)
    repeat (6) tick();
    res_q.delete();
    fill(1'b0, 8'h01, 8'hFF, 8'h7F);
    run(2, 1'b0, 1'b0, 8'h7F, {-32'sd100, 32'sd100, 32'sd0});
    res_q.delete();
    in_valid = 1'b0;
    set_beat(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, {32'd7, 32'd7, 32'd7});
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    expect_one("held", 2550, -2450, 323750);

    // Weight cascade: displaced column 2 comes out next cycle; source select from cascade input.
    w_load = 1'b1; w_bank = 1'b0; w_src = 1'b1;
    cascade_weight_in = {LANES{8'h55}}; w_data = {LANES{8'hAA}};
    tick();
    w_load = 1'b0; w_src = 1'b0;
    chk("cwv_set", cascade_weight_valid, 1);
    chk("cwo_val", longint'(cascade_weight_out == {LANES{8'h7F}}), 1);
    tick();
    chk("cwv_clr", cascade_weight_valid, 0);
    run(1, 1'b0, 1'b0, 8'h01, z);
    expect_one("wsrc", 850, 10, -10);

    // Fill bank B while streaming on A, then back-to-back runs across both banks.
    fill(1'b0, 8'h01, 8'h02, 8'h03);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] d;
      d = (k == 1) ? 8'h02 : 8'h01;
      set_beat(1'b1, 1'b1, (k == 3), 1'b0, d, z);
      if (k < 3) begin
        w_load = 1'b1; w_bank = 1'b1; w_src = 1'b0; w_data = {LANES{8'hFF}};
      end
      tick();
      w_load = 1'b0;
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("b2b_count", res_q.size(), 5);
    for (int k = 0; k < 5 && res_q.size() > 0; k++) begin
      logic [RW-1:0] r;
      int m;
      r = res_q.pop_front();
      m = (k == 1) ? 2 : 1;
      if (k == 3) begin
        for (int c = 0; c < COLS; c++) chk($sformatf("b2b%0d_c%0d", k, c), col_of(r, c), -10);
      end else begin
        for (int c = 0; c < COLS; c++)
          chk($sformatf("b2b%0d_c%0d", k, c), col_of(r, c), 10*m*(c+1));
      end
    end
    res_q.delete();
    chk("no_conflict", w_conflict, 0);

    set_beat(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, z);
    w_load = 1'b1; w_bank = 1'b0; w_data = {LANES{8'h01}};
    tick();
    w_load = 1'b0; in_valid = 1'b0;
    chk("conflict", w_conflict, 1);
    repeat (6) tick();
    res_q.delete();

    // Reset mid-run: partial run discarded, no strobe afterwards.
    set_beat(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, z); tick();
    set_beat(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, z); tick();
    set_beat(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, z); tick();
    in_valid = 1'b0;
    clr_n = 1'b0;
    #1;
    chk("mid_rst_result", longint'(|result), 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_conflict", w_conflict, 0);
    repeat (2) tick();
    clr_n = 1'b1;
    repeat (6) tick();
    chk("mid_rst_no_valid", res_q.size(), 0);

    // Overflow boundary: 12 beats fit, 13th overflows.
    fill(1'b0, 8'h80, 8'h80, 8'h80);
    run(12, 1'b0, 1'b0, 8'h80, z);
    expect_one("full12", 1966080, 1966080, 1966080);
    chk("ovf12", ovf, 0);
`ifdef MAC_INT8_ARRAY_SAT_EN
    sat_exp = 2097151;
`else
    sat_exp = -2064384;
`endif
    run(13, 1'b0, 1'b0, 8'h80, z);
    expect_one("ovf13", sat_exp, sat_exp, sat_exp);
    chk("ovf13_flag", ovf, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
